// File: rtl/utx_fifo_param_if.sv
// Upstream word handshake for the parametrised UART transmitter.
// Master queues words; slave (the transmitter) signals room.
interface utx_fifo_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic                 in_valid;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/utx_fifo_param.sv
// Parametrised UART transmitter with input FIFO.
// Frames run back-to-back; per-frame parity/stop latched at load.
module utx_fifo_param #(
  parameter int CLK_DIV    = 87,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  utx_fifo_param_if.slave             up,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  output logic                        serialout,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } st_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wp, rp;
  logic [AW:0]          cnt_q;
  logic                 empty, full, push, pop;

  st_t                  state;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        idx;
  logic                 sidx;
  logic [DATA_BITS-1:0] dat;
  logic                 par_q, pen_q, two_q;
  logic                 bit_end, stop_last, frame_end;
  logic                 line_d, fin;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == FULL);
  assign up.in_ready = !full;
  assign fifo_level = cnt_q;
  assign push       = up.in_valid && !full;

  assign bit_end    = (baud == CMAX);
  assign stop_last  = !two_q || sidx;
  assign frame_end  = (state == STOP) && bit_end && stop_last;
  assign pop        = !empty &&
                      ((state == IDLE) || frame_end);

  // FIFO storage; data path needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= up.in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Frame sequencer; a pop always restarts at START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      sidx  <= 1'b0;
      dat   <= '0;
      par_q <= 1'b0;
      pen_q <= 1'b0;
      two_q <= 1'b0;
    end else if (pop) begin
      state <= START;
      baud  <= '0;
      idx   <= '0;
      sidx  <= 1'b0;
      dat   <= mem[rp];
      pen_q <= parity_mode[0] ^ parity_mode[1];
      par_q <= (^mem[rp]) ^ parity_mode[1];
      two_q <= two_stop;
    end else begin
      unique case (state)
        IDLE: baud <= '0;
        START: begin
          if (bit_end) begin
            baud  <= '0;
            idx   <= '0;
            state <= DATA;
          end else baud <= baud + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (idx == BMAX) begin
              sidx  <= 1'b0;
              state <= pen_q ? PARITY : STOP;
            end else idx <= idx + 1'b1;
          end else baud <= baud + 1'b1;
        end
        PARITY: begin
          if (bit_end) begin
            baud  <= '0;
            sidx  <= 1'b0;
            state <= STOP;
          end else baud <= baud + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (stop_last) state <= IDLE;
            else           sidx  <= 1'b1;
          end else baud <= baud + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line level for the current bit
  always_comb begin
    line_d = 1'b1;
    unique case (1'b1)
      state == START:  line_d = 1'b0;
      state == DATA:   line_d = dat[idx];
      state == PARITY: line_d = par_q;
      default:         line_d = 1'b1;
    endcase
  end

  // Registered outputs, one clock behind the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serialout <= 1'b1;
      busy      <= 1'b0;
      fin       <= 1'b0;
      done      <= 1'b0;
    end else begin
      serialout <= line_d;
      busy      <= (state != IDLE);
      fin       <= frame_end;
      done      <= fin;
    end
  end
endmodule

// File: tb/tb_utx_fifo_param.sv
// Bench for utx_fifo_param: directed and random frames
// compared against a bit-list frame model.
module tb_utx_fifo_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pm0 = 2'b00, pm1 = 2'b00;
  logic       ts0 = 1'b0, ts1 = 1'b0;
  logic       so0, so1, bs0, bs1, dn0, dn1;
  logic [2:0] lv0, lv1;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  utx_fifo_param_if #(.DATA_BITS(8)) if0 ();
  utx_fifo_param_if #(.DATA_BITS(5)) if1 ();

  utx_fifo_param #(
    .CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst(rst), .up(if0.slave),
    .parity_mode(pm0), .two_stop(ts0),
    .serialout(so0), .busy(bs0), .done(dn0),
    .fifo_level(lv0)
  );

  utx_fifo_param #(
    .CLK_DIV(3), .DATA_BITS(5), .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst(rst), .up(if1.slave),
    .parity_mode(pm1), .two_stop(ts1),
    .serialout(so1), .busy(bs1), .done(dn1),
    .fifo_level(lv1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic g_line(input bit w);
    return w ? so1 : so0;
  endfunction
  function automatic logic g_busy(input bit w);
    return w ? bs1 : bs0;
  endfunction
  function automatic logic g_done(input bit w);
    return w ? dn1 : dn0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input bit w, input int d,
                      output int cp);
    if (w) begin
      if1.in_valid = 1'b1;
      if1.in_data  = 5'(d);
    end else begin
      if0.in_valid = 1'b1;
      if0.in_data  = 8'(d);
    end
    cp = cyc;
    @(negedge clk);
    if0.in_valid = 1'b0;
    if1.in_valid = 1'b0;
  endtask

  // Model: frame as a list of bit levels, each held div clocks
  task automatic expect_frame(input bit w, input int d,
                              input logic [1:0] pm,
                              input bit ts, input bit scr,
                              output int st, output int en);
    int div, db, n;
    bit q[$];
    bit p;
    div = w ? 3 : 4;
    db  = w ? 5 : 8;
    p   = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      q.push_back(bit'((d >> i) & 1));
      p ^= bit'((d >> i) & 1);
    end
    if (pm == 2'b01) q.push_back(p);
    if (pm == 2'b10) q.push_back(!p);
    q.push_back(1'b1);
    if (ts) q.push_back(1'b1);
    st = 0;
    en = 0;
    n  = 0;
    while (g_line(w) !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (g_line(w) !== 1'b0) begin
      chk("start_timeout", 32'(g_line(w)), 32'd0);
      return;
    end
    st = cyc;
    for (int k = 0; k < q.size() * div; k++) begin
      if (k > 0) @(negedge clk);
      if (scr && k == 0) begin
        pm0 = 2'($urandom_range(0, 3));
        ts0 = 1'($urandom_range(0, 1));
      end
      chk($sformatf("line%0d", k),
          32'(g_line(w)), 32'(q[k / div]));
      chk("busy_in", 32'(g_busy(w)), 32'd1);
      if (k > 0)
        chk("done_mid", 32'(g_done(w)), 32'd0);
    end
    en = cyc;
  endtask

  task automatic end_single(input bit w);
    @(negedge clk);
    chk("done_pulse", 32'(g_done(w)), 32'd1);
    chk("busy_end", 32'(g_busy(w)), 32'd0);
    @(negedge clk);
    chk("done_off", 32'(g_done(w)), 32'd0);
    chk("line_idle", 32'(g_line(w)), 32'd1);
  endtask

  initial begin
    int cp, st, en, st2, en2, d1, n, e, w, d;
    logic [1:0] pm;
    bit ts;
    int acc[$];
    if0.in_valid = 1'b0;
    if0.in_data  = '0;
    if1.in_valid = 1'b0;
    if1.in_data  = '0;

    repeat (3) @(negedge clk);
    chk("rst_line", 32'(so0), 32'd1);
    chk("rst_busy", 32'(bs0), 32'd0);
    chk("rst_done", 32'(dn0), 32'd0);
    chk("rst_level", 32'(lv0), 32'd0);
    chk("rst_ready", 32'(if0.in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // 8N1 frame and start latency
    push(1'b0, 8'h55, cp);
    expect_frame(1'b0, 8'h55, 2'b00, 1'b0, 1'b0, st, en);
    chk("start_lat", 32'(st - cp), 32'd3);
    chk("len_8n1", 32'(en - st + 1), 32'd40);
    end_single(1'b0);

    // Even then odd parity
    pm0 = 2'b01;
    push(1'b0, 8'h07, cp);
    expect_frame(1'b0, 8'h07, 2'b01, 1'b0, 1'b0, st, en);
    chk("len_even", 32'(en - st + 1), 32'd44);
    end_single(1'b0);
    pm0 = 2'b10;
    push(1'b0, 8'h07, cp);
    expect_frame(1'b0, 8'h07, 2'b10, 1'b0, 1'b0, st, en);
    chk("len_odd", 32'(en - st + 1), 32'd44);
    end_single(1'b0);

    // Two stop bits, back-to-back
    pm0 = 2'b00;
    ts0 = 1'b1;
    push(1'b0, 8'hA3, cp);
    push(1'b0, 8'h3C, cp);
    expect_frame(1'b0, 8'hA3, 2'b00, 1'b1, 1'b0, st, en);
    @(negedge clk);
    chk("done_a3", 32'(dn0), 32'd1);
    d1 = cyc;
    expect_frame(1'b0, 8'h3C, 2'b00, 1'b1, 1'b0, st2, en2);
    chk("b2b_gap", 32'(st2), 32'(en + 1));
    @(negedge clk);
    chk("done_3c", 32'(dn0), 32'd1);
    chk("done_space", 32'(cyc - d1), 32'd44);
    @(negedge clk);
    chk("done_off2", 32'(dn0), 32'd0);
    ts0 = 1'b0;
    repeat (2) @(negedge clk);

    // FIFO full while busy
    push(1'b0, 8'h11, cp);
    n = 0;
    while (bs0 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("busy_wait", 32'(bs0), 32'd1);
    e = 0;
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(0, 255);
      chk("ff_ready", 32'(if0.in_ready), 32'(e < 4));
      chk("ff_level", 32'(lv0), 32'(e));
      if0.in_valid = 1'b1;
      if0.in_data  = 8'(w);
      if (e < 4) begin
        acc.push_back(w);
        e++;
      end
      @(negedge clk);
    end
    if0.in_valid = 1'b0;
    chk("ff_level4", 32'(lv0), 32'd4);
    chk("ff_notready", 32'(if0.in_ready), 32'd0);
    n = 0;
    while (dn0 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ff_done0", 32'(dn0), 32'd1);
    chk("ff_lvl3", 32'(lv0), 32'd3);
    for (int i = 0; i < 4; i++) begin
      expect_frame(1'b0, acc[i], 2'b00, 1'b0, 1'b0, st, en);
      @(negedge clk);
      chk("ff_done", 32'(dn0), 32'd1);
      chk("ff_lvl", 32'(lv0), 32'(i < 3 ? 2 - i : 0));
    end
    @(negedge clk);
    chk("ff_idle", 32'(bs0), 32'd0);

    // Reset during data bit 3 with two queued
    push(1'b0, 8'hF0, cp);
    push(1'b0, 8'h0F, cp);
    push(1'b0, 8'h5A, cp);
    n = 0;
    while (so0 !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (17) @(negedge clk);
    chk("pre_rst_lvl", 32'(lv0), 32'd2);
    rst = 1'b1;
    #1;
    chk("mrst_line", 32'(so0), 32'd1);
    chk("mrst_busy", 32'(bs0), 32'd0);
    chk("mrst_lvl", 32'(lv0), 32'd0);
    chk("mrst_ready", 32'(if0.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (so0 !== 1'b1 || bs0 !== 1'b0) n++;
    end
    chk("post_rst_quiet", 32'(n), 32'd0);
    push(1'b0, 8'hC3, cp);
    expect_frame(1'b0, 8'hC3, 2'b00, 1'b0, 1'b0, st, en);
    end_single(1'b0);

    // Random frames; config scrambled mid-frame
    for (int it = 0; it < 8; it++) begin
      d  = $urandom_range(0, 255);
      pm = 2'($urandom_range(0, 3));
      ts = 1'($urandom_range(0, 1));
      pm0 = pm;
      ts0 = ts;
      push(1'b0, d, cp);
      expect_frame(1'b0, d, pm, ts, 1'b1, st, en);
      chk("rnd_len", 32'(en - st + 1),
          32'(4 * (9 + ((pm == 2'b01 || pm == 2'b10) ? 1 : 0)
                     + (ts ? 2 : 1))));
      end_single(1'b0);
    end

    // Five data bits, odd parity
    pm1 = 2'b10;
    push(1'b1, 5'h1F, cp);
    expect_frame(1'b1, 5'h1F, 2'b10, 1'b0, 1'b0, st, en);
    chk("len_5o1", 32'(en - st + 1), 32'd24);
    end_single(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
